exe_div: RTL and testbench

EXE_DIV -- requirements
Module: exe_div

---
 rtl/exe_div_pkg.sv | 18 +
 rtl/exe_div_if.sv | 25 ++
 rtl/exe_div_step.sv | 20 ++
 rtl/exe_div.sv | 108 ++++++++++
 tb/tb_exe_div.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/exe_div_pkg.sv
// Shared CPU defines for the EXE-stage divider: FSM encoding, step count and
// the operand magnitude helper used when latching signed operands.
package exe_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam int DIV_STEPS = 32;

    // 0x80000000 maps onto itself; the unsigned datapath still reads it as 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/exe_div_if.sv
// Handshake and data bundle between the EXE stage (master) and the divider (slave).
interface exe_div_if;

    logic        start;
    logic        is_sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        hold;
    logic        stall_req;
    logic        done;
    logic [31:0] lo_o;
    logic [31:0] hi_o;

    modport master (
        output start, is_sign, dividend, divisor, flush, hold,
        input  stall_req, done, lo_o, hi_o
    );

    modport slave (
        input  start, is_sign, dividend, divisor, flush, hold,
        output stall_req, done, lo_o, hi_o
    );

endinterface

// File: rtl/exe_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module div_step (
    input  logic [31:0] rem_in,
    input  logic        bit_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [33:0] trial;

    // Two guard bits: the shifted remainder can reach 2^33-1 when the divisor exceeds 2^31.
    assign shifted = {rem_in, bit_in};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~trial[33];
    assign rem_out = q_bit ? trial[31:0] : shifted[31:0];

endmodule

// File: rtl/exe_div.sv
// Multi-cycle 32-bit signed/unsigned divider for the EXE stage; stalls the
// pipeline while busy and presents LO (quotient) / HI (remainder) in DONE.
module exe_div
    import exe_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    exe_div_if.slave   bus
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_e  state;
    div_state_e  state_next;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        q_sign;
    logic        r_sign;
    logic        div_zero;
    logic [31:0] rem_next;
    logic        q_bit;
    logic [31:0] quo_next;
    logic        accept;
    logic        stepping;
    logic        last_step;
    logic [31:0] lo_r;
    logic [31:0] hi_r;

    div_step u_step (
        .rem_in  (rem),
        .bit_in  (quo[31]),
        .divisor (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign quo_next  = {quo[30:0], q_bit};
    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign stepping  = (state == BUSY) && !bus.flush;
    assign last_step = stepping && (cnt == LAST_STEP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)      state_next = BUSY;
            BUSY:    if (cnt == LAST_STEP) state_next = DONE;
            DONE:    if (!bus.hold)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The quotient register starts out holding the dividend magnitude and shifts it out
    // MSB-first while the quotient bits shift in from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_sign   <= 1'b0;
            r_sign   <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= magnitude(bus.dividend, bus.is_sign);
            dvs      <= magnitude(bus.divisor, bus.is_sign);
            q_sign   <= (bus.dividend[31] ^ bus.divisor[31]) & bus.is_sign;
            r_sign   <= bus.dividend[31] & bus.is_sign;
            div_zero <= (bus.divisor == 32'd0);
        end else if (stepping) begin
            cnt <= cnt + 6'd1;
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    // With a zero divisor the remainder path degenerates into a plain shift register, so
    // re-applying the dividend sign restores the dividend exactly as it was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= '0;
            hi_r <= '0;
        end else if (last_step) begin
            lo_r <= div_zero ? 32'hFFFF_FFFF : (q_sign ? -quo_next : quo_next);
            hi_r <= r_sign ? -rem_next : rem_next;
        end
    end

    assign bus.lo_o      = lo_r;
    assign bus.hi_o      = hi_r;
    assign bus.done      = (state == DONE);
    assign bus.stall_req = rst_n & ~bus.flush & (((state == IDLE) & bus.start) | (state == BUSY));

endmodule

// File: tb/tb_exe_div.sv
// Self-checking bench for exe_div: directed corner cases plus randomized divides,
// checked by a scoreboard against an arithmetic reference model.
module tb_exe_div;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    exe_div_if bus ();

    exe_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: every rising edge of done retires one expected result.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (bus.done === 1'b1 && !prev_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: done rose with no divide outstanding (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check_output("result_lo", bus.lo_o, e.lo);
                    check_output("result_hi", bus.hi_o, e.hi);
                    check_output("result_latency", 32'(cyc), 32'(e.due));
                end
            end
            prev_done = (bus.done === 1'b1);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold_n);
        exp_t e;
        logic [63:0] r;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        bus.is_sign  = sgn;
        r     = ref_div(a, b, sgn);
        e.lo  = r[63:32];
        e.hi  = r[31:0];
        e.due = cyc + 33;
        sb_q.push_back(e);
        #1 check_output("stall_accept", 32'(bus.stall_req), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = $urandom();
            bus.divisor  = $urandom();
            bus.is_sign  = 1'($urandom_range(0, 1));
            #1 check_output("stall_busy", 32'(bus.stall_req), 32'd1);
        end
        @(negedge clk);
        bus.start = (hold_n > 0);
        bus.hold  = (hold_n > 0);
        #1;
        check_output("stall_done", 32'(bus.stall_req), 32'd0);
        check_output("done_flag", 32'(bus.done), 32'd1);
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            if (h == hold_n - 1) begin
                bus.hold  = 1'b0;
                bus.start = 1'b0;
            end
            #1;
            check_output("hold_done", 32'(bus.done), 32'd1);
            check_output("hold_lo", bus.lo_o, e.lo);
            check_output("hold_hi", bus.hi_o, e.hi);
        end
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    task automatic flush_test(input logic [31:0] a, input logic [31:0] b, input int step);
        logic saw_done;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        bus.is_sign  = 1'b0;
        for (int i = 0; i <= step; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        bus.start = 1'b1;
        #1 check_output("flush_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        check_output("flush_idle", 32'(bus.stall_req), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1 saw_done |= (bus.done === 1'b1);
        end
        check_output("flush_no_done", 32'(saw_done), 32'd0);
        check_output("flush_lo_kept", bus.lo_o, last_lo);
        check_output("flush_hi_kept", bus.hi_o, last_hi);
    endtask

    task automatic reset_test(input logic [31:0] a, input logic [31:0] b, input int step);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        bus.is_sign  = 1'b0;
        for (int i = 0; i <= step; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n     = 1'b0;
        bus.start = 1'b1;
        #1;
        check_output("rst_stall", 32'(bus.stall_req), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_lo", bus.lo_o, 32'd0);
        check_output("rst_hi", bus.hi_o, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        last_lo   = '0;
        last_hi   = '0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.is_sign  = 1'b0;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.flush    = 1'b0;
        bus.hold     = 1'b0;
        #3;
        check_output("reset_stall", 32'(bus.stall_req), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
        check_output("reset_lo", bus.lo_o, 32'd0);
        check_output("reset_hi", bus.hi_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div(32'd5, 32'd0, 1'b0, 0);
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
        run_div(32'hDEAD_BEEF, 32'h9000_0001, 1'b0, 0);
        flush_test(32'd1000, 32'd3, 10);
        run_div(32'd123456, 32'd789, 1'b0, 3);
        run_div(32'd9, 32'd3, 1'b0, 0);
        reset_test(32'd100, 32'd7, 20);
        run_div(32'd100, 32'd7, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            a = $urandom();
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom() >> $urandom_range(0, 31);
                default: b = $urandom();
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
